teclado_cajero: RTL and testbench
=================================

Name: teclado_cajero

Overview:
- Keypad front-end for the ATM controller; sits directly upstream of it.
- Converts debounced raw key presses into the controller's entry strobes: single-digit PIN strobes (DIGITO/DIGITO_STB) and a decimal-accumulated 32-bit amount (MONTO/MONTO_STB).
- Also reports cancel and amount-overflow events.
- Mode (PIN vs amount entry) and lockout are driven back from the controller.

Parameters:
- MAX_DIGITOS, 9: maximum decimal digits accepted in one amount entry. 9 guarantees the result fits 32 bits.
- ANCHO_MONTO, 32: width of the amount accumulator and of MONTO.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- TECLA_VALIDA  input  1  high while a key is pressed (already debounced).
- TECLA  input  4  key code: 0-9 digit, 4'hA ENTER, 4'hB BORRAR, 4'hC CANCELAR, 4'hD-4'hF unused.
- ESPERANDO_MONTO  input  1  from controller: 1 = amount entry, 0 = PIN entry.
- BLOQUEO  input  1  from controller: 1 = all keys ignored.
- DIGITO  output  4  last PIN digit delivered.
- DIGITO_STB  output  1  one-cycle pulse, DIGITO valid.
- MONTO  output  ANCHO_MONTO  last committed amount, binary.
- MONTO_STB  output  1  one-cycle pulse, MONTO valid.
- CANCELAR_STB  output  1  one-cycle pulse on CANCELAR key.
- DESBORDE  output  1  one-cycle pulse, digit rejected for exceeding MAX_DIGITOS.

Behaviour:
- Reset (async, any time):
  - DIGITO=0, DIGITO_STB=0, MONTO=0, MONTO_STB=0, CANCELAR_STB=0, DESBORDE=0.
  - Accumulator=0, digit count=0, state=ESPERA_PIN.
  - valida_prev=1, so a key held through reset deassertion produces no event.
- Event detection:
  - evento = TECLA_VALIDA & ~valida_prev, sampled each edge.
  - Exactly one event per press; holding a key never repeats.
  - TECLA is sampled at the event edge.
- Latency: all strobes are registered.
  - If TECLA_VALIDA is sampled 0 at edge k-1 and 1 at edge k, the strobe is high from edge k to edge k+1.
- Strobes default to 0 every cycle and are never high for two consecutive cycles.
- FSM states: ESPERA_PIN, ACUM_MONTO.
  - Next state = ACUM_MONTO when ESPERANDO_MONTO=1, else ESPERA_PIN.
  - An event is interpreted under the ESPERANDO_MONTO value sampled at the same edge.
  - Entering ESPERA_PIN clears accumulator and count. On a 0->1 transition, a coincident digit is the first amount digit, with the accumulator starting from 0.
- BLOQUEO=1: events are discarded (no strobes, no accumulator change); the FSM still tracks ESPERANDO_MONTO.
- ESPERA_PIN:
  - Digit d: DIGITO<=d, DIGITO_STB pulse.
  - CANCELAR: CANCELAR_STB pulse.
  - ENTER, BORRAR and unused codes: ignored.
- ACUM_MONTO:
  - Digit d with count<MAX_DIGITOS: acc<=acc*10+d (acc*10 computed as (acc<<3)+(acc<<1), truncated to ANCHO_MONTO); count++.
  - Leading zeros count as digits.
  - Digit with count==MAX_DIGITOS: DESBORDE pulse; acc and count unchanged.
  - ENTER with count>0: MONTO<=acc, MONTO_STB pulse, acc<=0, count<=0.
  - ENTER with count==0: ignored.
  - BORRAR: acc<=0, count<=0, no strobe.
  - CANCELAR: acc<=0, count<=0, CANCELAR_STB pulse.
  - DIGITO_STB is never asserted in this state.
- Output holding:
  - MONTO and DIGITO hold until overwritten or reset.
  - MONTO is never updated without MONTO_STB.
- Codes 4'hD-4'hF: ignored in all states.

Test Plan:
- Reset, ESPERANDO_MONTO=0, press 6,5,7,5 (each held 2 cycles, 1 cycle released) -> four DIGITO_STB pulses, one cycle each, DIGITO=6,5,7,5; MONTO stays 0.
- Key 3 held for 6 cycles in PIN mode -> exactly one DIGITO_STB, DIGITO=3.
- ESPERANDO_MONTO=1, press 1,2,5,0,ENTER -> no DIGITO_STB; a single MONTO_STB with MONTO=1250 (32'h000004E2).
- Amount mode, press 9 ten times then ENTER -> DESBORDE pulses once, on the 10th press; MONTO=999999999 (32'h3B9AC9FF).
- Amount mode sequence:
  - 4, BORRAR, ENTER -> no MONTO_STB.
  - 8, CANCELAR -> CANCELAR_STB, accumulator cleared.
  - 7, ENTER -> MONTO=7.
- BLOQUEO=1 with digits and ENTER pressed -> no strobes, MONTO unchanged.
- RESET asserted mid-press while key held, then released with key still held -> no strobe until the key is released and pressed again.

Source files
------------

// File: rtl/teclado_cajero.sv
// Keypad front-end for the ATM controller: turns debounced key presses into
// registered PIN digit strobes, a decimal-accumulated amount, cancel and overflow pulses.
module teclado_cajero #(
    parameter int MAX_DIGITOS = 9,
    parameter int ANCHO_MONTO = 32
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   TECLA_VALIDA,
    input  logic [3:0]             TECLA,
    input  logic                   ESPERANDO_MONTO,
    input  logic                   BLOQUEO,
    output logic [3:0]             DIGITO,
    output logic                   DIGITO_STB,
    output logic [ANCHO_MONTO-1:0] MONTO,
    output logic                   MONTO_STB,
    output logic                   CANCELAR_STB,
    output logic                   DESBORDE
);

    localparam int CW = $clog2(MAX_DIGITOS + 1);

    localparam logic [3:0] K_ENTER    = 4'hA;
    localparam logic [3:0] K_BORRAR   = 4'hB;
    localparam logic [3:0] K_CANCELAR = 4'hC;

    typedef enum logic {ESPERA_PIN, ACUM_MONTO} estado_t;

    estado_t                estado_q, estado_d;
    logic [ANCHO_MONTO-1:0] acc_q, acc_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   valida_prev_q;
    logic [3:0]             digito_q, digito_d;
    logic [ANCHO_MONTO-1:0] monto_q, monto_d;
    logic                   digito_stb_q, digito_stb_d;
    logic                   monto_stb_q, monto_stb_d;
    logic                   cancelar_stb_q, cancelar_stb_d;
    logic                   desborde_q, desborde_d;

    logic                   evento;
    logic                   es_digito;
    logic [ANCHO_MONTO-1:0] base_acc;
    logic [CW-1:0]          base_cnt;
    logic [ANCHO_MONTO-1:0] acc_x10;

    always_comb begin
        estado_d       = ESPERANDO_MONTO ? ACUM_MONTO : ESPERA_PIN;
        evento         = TECLA_VALIDA & ~valida_prev_q & ~BLOQUEO;
        es_digito      = (TECLA <= 4'd9);
        // A 0->1 mode change starts the amount from zero even on a coincident digit.
        base_acc       = (estado_q == ACUM_MONTO) ? acc_q : '0;
        base_cnt       = (estado_q == ACUM_MONTO) ? cnt_q : '0;
        acc_x10        = (base_acc << 3) + (base_acc << 1) + ANCHO_MONTO'(TECLA);
        acc_d          = ESPERANDO_MONTO ? base_acc : '0;
        cnt_d          = ESPERANDO_MONTO ? base_cnt : '0;
        digito_d       = digito_q;
        monto_d        = monto_q;
        digito_stb_d   = 1'b0;
        monto_stb_d    = 1'b0;
        cancelar_stb_d = 1'b0;
        desborde_d     = 1'b0;

        if (evento) begin
            if (!ESPERANDO_MONTO) begin
                if (es_digito) begin
                    digito_d     = TECLA;
                    digito_stb_d = 1'b1;
                end else if (TECLA == K_CANCELAR) begin
                    cancelar_stb_d = 1'b1;
                end
            end else if (es_digito) begin
                if (base_cnt < CW'(MAX_DIGITOS)) begin
                    acc_d = acc_x10;
                    cnt_d = base_cnt + 1'b1;
                end else begin
                    desborde_d = 1'b1;
                end
            end else begin
                case (TECLA)
                    K_ENTER: begin
                        if (base_cnt != '0) begin
                            monto_d     = base_acc;
                            monto_stb_d = 1'b1;
                            acc_d       = '0;
                            cnt_d       = '0;
                        end
                    end
                    K_BORRAR: begin
                        acc_d = '0;
                        cnt_d = '0;
                    end
                    K_CANCELAR: begin
                        acc_d          = '0;
                        cnt_d          = '0;
                        cancelar_stb_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // valida_prev resets high so a key held across reset release is not an event.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            estado_q       <= ESPERA_PIN;
            acc_q          <= '0;
            cnt_q          <= '0;
            valida_prev_q  <= 1'b1;
            digito_q       <= '0;
            monto_q        <= '0;
            digito_stb_q   <= 1'b0;
            monto_stb_q    <= 1'b0;
            cancelar_stb_q <= 1'b0;
            desborde_q     <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            valida_prev_q  <= TECLA_VALIDA;
            digito_q       <= digito_d;
            monto_q        <= monto_d;
            digito_stb_q   <= digito_stb_d;
            monto_stb_q    <= monto_stb_d;
            cancelar_stb_q <= cancelar_stb_d;
            desborde_q     <= desborde_d;
        end
    end

    assign DIGITO       = digito_q;
    assign DIGITO_STB   = digito_stb_q;
    assign MONTO        = monto_q;
    assign MONTO_STB    = monto_stb_q;
    assign CANCELAR_STB = cancelar_stb_q;
    assign DESBORDE     = desborde_q;

endmodule

// File: tb/tb_teclado_cajero.sv
// Directed bench for teclado_cajero: strobe counts and captured values are
// compared against hand-computed expectations.
module tb_teclado_cajero;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        TECLA_VALIDA;
    logic [3:0]  TECLA;
    logic        ESPERANDO_MONTO;
    logic        BLOQUEO;
    logic [3:0]  DIGITO;
    logic        DIGITO_STB;
    logic [31:0] MONTO;
    logic        MONTO_STB;
    logic        CANCELAR_STB;
    logic        DESBORDE;

    int checks = 0;
    int errors = 0;

    int n_dig = 0, n_mon = 0, n_can = 0, n_des = 0, n_dbl = 0;
    logic [3:0] dig_log [16];
    logic p_dig = 0, p_mon = 0, p_can = 0, p_des = 0;
    int b_dig, b_mon, b_can, b_des;

    teclado_cajero #(.MAX_DIGITOS(9), .ANCHO_MONTO(32)) dut (
        .CLK(CLK), .RESET(RESET), .TECLA_VALIDA(TECLA_VALIDA), .TECLA(TECLA),
        .ESPERANDO_MONTO(ESPERANDO_MONTO), .BLOQUEO(BLOQUEO),
        .DIGITO(DIGITO), .DIGITO_STB(DIGITO_STB), .MONTO(MONTO), .MONTO_STB(MONTO_STB),
        .CANCELAR_STB(CANCELAR_STB), .DESBORDE(DESBORDE)
    );

    always #5 CLK = ~CLK;

    // Strobe monitor, sampled mid-cycle.
    always @(negedge CLK) begin
        if (DIGITO_STB) begin
            dig_log[n_dig % 16] <= DIGITO;
            n_dig <= n_dig + 1;
        end
        if (MONTO_STB)    n_mon <= n_mon + 1;
        if (CANCELAR_STB) n_can <= n_can + 1;
        if (DESBORDE)     n_des <= n_des + 1;
        if ((DIGITO_STB && p_dig) || (MONTO_STB && p_mon) ||
            (CANCELAR_STB && p_can) || (DESBORDE && p_des))
            n_dbl <= n_dbl + 1;
        p_dig <= DIGITO_STB;
        p_mon <= MONTO_STB;
        p_can <= CANCELAR_STB;
        p_des <= DESBORDE;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d (0x%08h) expected=%0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic press(input logic [3:0] k, input int hold);
        TECLA        = k;
        TECLA_VALIDA = 1'b1;
        cyc(hold);
        TECLA_VALIDA = 1'b0;
        cyc(1);
    endtask

    task automatic snap();
        cyc(2);
        b_dig = n_dig;
        b_mon = n_mon;
        b_can = n_can;
        b_des = n_des;
    endtask

    initial begin
        RESET = 1'b1;
        TECLA_VALIDA = 1'b0;
        TECLA = 4'h0;
        ESPERANDO_MONTO = 1'b0;
        BLOQUEO = 1'b0;
        cyc(3);
        chk("rst_digito", 32'(DIGITO), 0);
        chk("rst_monto", MONTO, 0);
        chk("rst_strobes", {28'd0, DIGITO_STB, MONTO_STB, CANCELAR_STB, DESBORDE}, 0);
        RESET = 1'b0;
        snap();

        // PIN digits 6,5,7,5
        press(4'd6, 2); press(4'd5, 2); press(4'd7, 2); press(4'd5, 2);
        cyc(2);
        chk("pin_count", n_dig - b_dig, 4);
        chk("pin_d0", 32'(dig_log[b_dig % 16]), 6);
        chk("pin_d1", 32'(dig_log[(b_dig + 1) % 16]), 5);
        chk("pin_d2", 32'(dig_log[(b_dig + 2) % 16]), 7);
        chk("pin_d3", 32'(dig_log[(b_dig + 3) % 16]), 5);
        chk("pin_monto", MONTO, 0);
        chk("pin_no_monto_stb", n_mon - b_mon, 0);

        // Held key produces a single event
        snap();
        press(4'd3, 6);
        cyc(1);
        chk("hold_count", n_dig - b_dig, 1);
        chk("hold_digito", 32'(DIGITO), 3);

        // Unused code and cancel in PIN mode
        snap();
        press(4'hD, 2); press(4'hA, 2); press(4'hC, 2);
        cyc(1);
        chk("pin_unused_dig", n_dig - b_dig, 0);
        chk("pin_cancel", n_can - b_can, 1);

        // Amount 1250
        ESPERANDO_MONTO = 1'b1;
        snap();
        press(4'd1, 2); press(4'd2, 2); press(4'd5, 2); press(4'd0, 2);
        chk("amt_no_early_stb", n_mon - b_mon, 0);
        press(4'hA, 2);
        cyc(1);
        chk("amt_no_digito_stb", n_dig - b_dig, 0);
        chk("amt_stb", n_mon - b_mon, 1);
        chk("amt_1250", MONTO, 32'h0000_04E2);

        // Overflow on the tenth 9
        snap();
        for (int i = 0; i < 9; i++) press(4'd9, 2);
        cyc(1);
        chk("ovf_none_9", n_des - b_des, 0);
        press(4'd9, 2);
        cyc(1);
        chk("ovf_on_10", n_des - b_des, 1);
        press(4'hA, 2);
        cyc(1);
        chk("ovf_monto", MONTO, 32'h3B9A_C9FF);
        chk("ovf_stb", n_mon - b_mon, 1);

        // Borrar, then enter with nothing pending
        snap();
        press(4'd4, 2); press(4'hB, 2); press(4'hA, 2);
        cyc(1);
        chk("borrar_no_stb", n_mon - b_mon, 0);
        chk("borrar_monto_hold", MONTO, 32'h3B9A_C9FF);

        // Cancel clears the accumulator
        snap();
        press(4'd8, 2); press(4'hC, 2);
        cyc(1);
        chk("cancel_stb", n_can - b_can, 1);
        press(4'd7, 2); press(4'hA, 2);
        cyc(1);
        chk("cancel_then_7", MONTO, 7);
        chk("cancel_then_7_stb", n_mon - b_mon, 1);

        // Lockout
        BLOQUEO = 1'b1;
        snap();
        press(4'd3, 2); press(4'd4, 2); press(4'hA, 2); press(4'hC, 2);
        cyc(1);
        chk("lock_mon", n_mon - b_mon, 0);
        chk("lock_can", n_can - b_can, 0);
        chk("lock_monto", MONTO, 7);
        // Locked digits must not have reached the accumulator either
        BLOQUEO = 1'b0;
        press(4'd2, 2); press(4'hA, 2);
        cyc(1);
        chk("unlock_monto", MONTO, 2);
        ESPERANDO_MONTO = 1'b0;
        BLOQUEO = 1'b1;
        snap();
        press(4'd4, 2);
        cyc(1);
        chk("lock_pin", n_dig - b_dig, 0);
        BLOQUEO = 1'b0;

        // Reset while a key is held
        snap();
        TECLA = 4'd2;
        TECLA_VALIDA = 1'b1;
        cyc(2);
        RESET = 1'b1;
        cyc(2);
        chk("rst_mid_monto", MONTO, 0);
        RESET = 1'b0;
        cyc(4);
        chk("rst_held_count", n_dig - b_dig, 1);
        chk("rst_held_digito", 32'(DIGITO), 0);
        TECLA_VALIDA = 1'b0;
        cyc(1);
        press(4'd2, 2);
        cyc(1);
        chk("rst_repress_count", n_dig - b_dig, 2);
        chk("rst_repress_digito", 32'(DIGITO), 2);

        chk("no_double_strobe", n_dbl, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
